// File: rtl/sl_change_logger_pkg.sv
// Shared defaults and event-record helpers for the change logger and its FIFO.
package sl_change_logger_pkg;

    // Defaults match the upstream second_largest stage.
    localparam int SL_WIDTH = 16;
    localparam int SL_TS_W  = 16;
    localparam int SL_DEPTH = 8;
    localparam int SL_CNT_W = 8;

    // An event record is packed as {stamp, value}: stamp in the upper bits.
    function automatic int ev_width(input int ts_w, input int width);
        return ts_w + width;
    endfunction

    // Occupancy counters need one bit more than the address so 0..DEPTH fits.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sl_change_logger_if.sv
// Valid/ready event port of the change logger: head event value and stamp.
interface sl_change_logger_if #(
    parameter int WIDTH = 16,
    parameter int TS_W  = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [TS_W-1:0]  out_stamp;

    // Logger side drives the event, reader side drives ready.
    modport master (output out_valid, output out_value, output out_stamp, input out_ready);
    modport slave  (input out_valid, input out_value, input out_stamp, output out_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head entry is visible on dout
// as soon as it is written, and dout reads 0 while the FIFO is empty.
module sync_fifo_fwft
    import sl_change_logger_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clr,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pop,
    output logic [DW-1:0]              dout,
    output logic [lvl_width(DEPTH)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_width(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    // A pop on a full FIFO frees the slot a same-cycle push needs.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointer and occupancy next state; clear beats push and pop.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
            else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; empty/level already say which entries are meaningful.
        if (push_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    // Head entry read combinationally, forced to 0 while empty.
    always_comb begin
        dout = '0;
        if (!empty) dout = mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: rtl/sl_change_logger.sv
// Change logger: samples the second_largest result, logs each change as a
// {stamp, value} event into a FWFT FIFO and drains it over valid/ready.
// Overflowed events are dropped and counted; the overflow flag is sticky.
module sl_change_logger
    import sl_change_logger_pkg::*;
#(
    parameter int WIDTH = SL_WIDTH,
    parameter int TS_W  = SL_TS_W,
    parameter int DEPTH = SL_DEPTH,
    parameter int CNT_W = SL_CNT_W
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        clr,
    input  logic                        en,
    input  logic [WIDTH-1:0]            sl_din,
    sl_change_logger_if.master          out_if,
    output logic [lvl_width(DEPTH)-1:0] level,
    output logic                        overflow,
    output logic [CNT_W-1:0]            drop_cnt
);

    localparam int DW = ev_width(TS_W, WIDTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             first_q, first_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             ev, push, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [DW-1:0]    head;

    // Event detection and the accept/drop decision for the FIFO.
    always_comb begin
        pop  = out_if.out_valid & out_if.out_ready;
        ev   = en & (first_q | (sl_din != prev_q));
        push = ev & (~fifo_full | pop);
        drop = ev & fifo_full & ~pop;
    end

    // Timestamp, change tracking and drop accounting; clear beats everything.
    always_comb begin
        ts_d       = ts_q + 1'b1;
        prev_d     = prev_q;
        first_d    = first_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            ts_d       = '0;
            first_d    = 1'b1;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            // A dropped sample still becomes the reference, so its repeats stay quiet.
            if (en) begin
                prev_d  = sl_din;
                first_d = 1'b0;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // Logger state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_q       <= '0;
            prev_q     <= '0;
            first_q    <= 1'b1;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            first_q    <= first_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo_fwft #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .push   (push),
        .din    ({ts_q, sl_din}),
        .pop    (pop),
        .dout   (head),
        .level  (level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_if.out_valid = ~fifo_empty;
    assign out_if.out_stamp = head[DW-1:WIDTH];
    assign out_if.out_value = head[WIDTH-1:0];
    assign overflow         = overflow_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_sl_change_logger.sv
// Bench for sl_change_logger: directed scenarios plus random traffic, checked
// every cycle against a queue-based event model. A second instance with a
// 4-bit timestamp shares all stimulus to exercise stamp wrap.
module tb_sl_change_logger;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int SAT   = 255;

    logic        clk;
    logic        resetn;
    logic        clr;
    logic        en;
    logic [15:0] din;
    logic        rdy;

    logic [3:0]  level_a, level_b;
    logic        ovf_a, ovf_b;
    logic [7:0]  drop_a, drop_b;

    sl_change_logger_if #(.WIDTH(16), .TS_W(16)) if_a ();
    sl_change_logger_if #(.WIDTH(16), .TS_W(4))  if_b ();

    assign if_a.out_ready = rdy;
    assign if_b.out_ready = rdy;

    sl_change_logger #(.WIDTH(16), .TS_W(16), .DEPTH(8), .CNT_W(8)) dut_a (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (clr),
        .en       (en),
        .sl_din   (din),
        .out_if   (if_a),
        .level    (level_a),
        .overflow (ovf_a),
        .drop_cnt (drop_a)
    );

    sl_change_logger #(.WIDTH(16), .TS_W(4), .DEPTH(8), .CNT_W(8)) dut_b (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (clr),
        .en       (en),
        .sl_din   (din),
        .out_if   (if_b),
        .level    (level_b),
        .overflow (ovf_b),
        .drop_cnt (drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: events as {unbounded stamp, value} in a queue.
    typedef struct {
        int unsigned stamp;
        int unsigned value;
    } ev_t;

    ev_t         mq[$];
    int unsigned m_ts;
    logic [15:0] m_prev;
    bit          m_first;
    bit          m_ovf;
    int unsigned m_drop;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts    = 0;
        m_prev  = '0;
        m_first = 1'b1;
        m_ovf   = 1'b0;
        m_drop  = 0;
    endtask

    // One clock edge of the logger, from the current input values.
    task automatic model_step();
        bit do_pop;
        bit is_ev;
        if (clr) begin
            mq.delete();
            m_ts    = 0;
            m_first = 1'b1;
            m_ovf   = 1'b0;
            m_drop  = 0;
        end else begin
            do_pop = (mq.size() > 0) && rdy;
            is_ev  = en && (m_first || din != m_prev);
            if (do_pop) void'(mq.pop_front());
            if (is_ev) begin
                if (mq.size() < DEPTH) mq.push_back('{m_ts, din});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < SAT) m_drop++;
                end
            end
            if (en) begin
                m_prev  = din;
                m_first = 1'b0;
            end
            m_ts++;
        end
    endtask

    task automatic compare_all();
        int unsigned ev_v, ev_s;
        ev_v = 0;
        ev_s = 0;
        if (mq.size() > 0) begin
            ev_v = mq[0].value;
            ev_s = mq[0].stamp;
        end
        check("valid_a", if_a.out_valid, mq.size() > 0);
        check("level_a", level_a, mq.size());
        check("value_a", if_a.out_value, ev_v);
        check("stamp_a", if_a.out_stamp, ev_s % 65536);
        check("ovf_a",   ovf_a, m_ovf);
        check("drop_a",  drop_a, m_drop);
        check("valid_b", if_b.out_valid, mq.size() > 0);
        check("level_b", level_b, mq.size());
        check("value_b", if_b.out_value, ev_v);
        check("stamp_b", if_b.out_stamp, ev_s % 16);
        check("drop_b",  drop_b, m_drop);
    endtask

    task automatic cyc(input bit c, input bit e, input logic [15:0] d, input bit r);
        clr = c;
        en  = e;
        din = d;
        rdy = r;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int unsigned exp_ts;
    int          rmode;

    initial begin
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        clr    = 1'b0;
        en     = 1'b0;
        din    = '0;
        rdy    = 1'b0;
        model_reset();

        // Reset state after two held cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        check("rst_valid", if_a.out_valid, 1'b0);
        check("rst_drop",  drop_a, 8'd0);
        resetn = 1'b1;

        // Change log starting at ts=5.
        for (int i = 0; i < 5; i++) cyc(0, 0, 16'd0, 1);
        cyc(0, 1, 16'd0, 1);
        check("log_s5",  if_a.out_stamp, 16'd5);
        check("log_v0",  if_a.out_value, 16'd0);
        cyc(0, 1, 16'd3, 1);
        check("log_s6",  if_a.out_stamp, 16'd6);
        cyc(0, 1, 16'd3, 1);
        check("log_rep", if_a.out_valid, 1'b0);
        cyc(0, 1, 16'd3, 1);
        cyc(0, 1, 16'd7, 1);
        check("log_s9",  if_a.out_stamp, 16'd9);
        cyc(0, 1, 16'd10, 1);
        check("log_s10", if_a.out_stamp, 16'd10);
        check("log_v10", if_a.out_value, 16'd10);
        cyc(0, 0, 16'd0, 1);

        // Overflow with the reader stalled, then drain in order.
        for (int i = 0; i < 10; i++) cyc(0, 1, 16'(100 + i), 0);
        check("ovf_level", level_a, 4'd8);
        check("ovf_flag",  ovf_a, 1'b1);
        check("ovf_drop",  drop_a, 8'd2);
        for (int i = 0; i < 8; i++) begin
            check("drain_val", if_a.out_value, 16'(100 + i));
            cyc(0, 0, 16'd0, 1);
        end
        check("drain_empty", if_a.out_valid, 1'b0);

        // Full FIFO with a same-cycle pop and push.
        for (int i = 0; i < 8; i++) cyc(0, 1, 16'(200 + i), 0);
        cyc(0, 1, 16'd300, 1);
        check("pp_level", level_a, 4'd8);
        check("pp_drop",  drop_a, 8'd2);
        for (int i = 0; i < 8; i++) begin
            check("pp_order", if_a.out_value, (i < 7) ? 16'(201 + i) : 16'd300);
            cyc(0, 0, 16'd0, 1);
        end

        // Backpressure: one event held for five cycles, then a single pop.
        exp_ts = m_ts;
        cyc(0, 1, 16'd55, 0);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", if_a.out_valid, 1'b1);
            check("bp_value", if_a.out_value, 16'd55);
            check("bp_stamp", if_a.out_stamp, 16'(exp_ts));
            cyc(0, 0, 16'd0, 0);
        end
        cyc(0, 0, 16'd0, 1);
        check("bp_pop", level_a, 4'd0);
        cyc(0, 0, 16'd0, 0);
        check("bp_one", level_a, 4'd0);

        // Clear with three queued events; the same value is logged again after it.
        cyc(0, 1, 16'd1, 0);
        cyc(0, 1, 16'd2, 0);
        cyc(0, 1, 16'd3, 0);
        check("clr_pre", level_a, 4'd3);
        cyc(1, 0, 16'd0, 0);
        check("clr_level", level_a, 4'd0);
        check("clr_ovf",   ovf_a, 1'b0);
        check("clr_drop",  drop_a, 8'd0);
        cyc(0, 1, 16'd3, 1);
        check("clr_first", if_a.out_valid, 1'b1);
        check("clr_ts0",   if_a.out_stamp, 16'd0);
        check("clr_v3",    if_a.out_value, 16'd3);

        // Stamp wrap of the 4-bit-timestamp instance.
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 16'(600 + i), 1);
            if (i == 15) check("wrap_15", if_b.out_stamp, 4'd15);
            if (i == 16) begin
                check("wrap_0",  if_b.out_stamp, 4'd0);
                check("wrap_16", if_a.out_stamp, 16'd16);
            end
        end

        // Drop counter saturation with the reader stalled.
        for (int i = 0; i < 300; i++) cyc(0, 1, (i % 2 == 0) ? 16'd1 : 16'd2, 0);
        check("sat_drop", drop_a, 8'd255);
        cyc(1, 0, 16'd0, 0);

        // Random traffic with varying reader speed and occasional clears.
        rmode = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rmode = int'($urandom_range(0, 8));
            cyc(($urandom % 150) == 0,
                ($urandom % 4) != 0,
                16'($urandom % 4),
                int'($urandom % 8) < rmode);
        end

        // Reset in the middle of a drain takes effect without a clock edge.
        cyc(1, 0, 16'd0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 16'(700 + i), 0);
        cyc(0, 0, 16'd0, 1);
        check("mid_level", level_a, 4'd4);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check("arst_valid_a", if_a.out_valid, 1'b0);
        check("arst_valid_b", if_b.out_valid, 1'b0);
        check("arst_level",   level_a, 4'd0);
        check("arst_value",   if_a.out_value, 16'd0);
        @(posedge clk);
        #1;
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
